fp_ieee_pair_unpacker: RTL and testbench
========================================

// Module: fp_ieee_pair_unpacker
// PURPOSE
//  Operand front end for the single-path FP adder. Accepts IEEE-754 operand pairs plus an add/sub flag over a valid/ready handshake.
//  Converts each operand to the internal format {exception[1:0], sign, exponent, mantissa w/o hidden bit}.
//  Delivers the pair through a 2-stage pipeline with full backpressure, and counts denormals that it flushes to zero.
// PARAMETERS
//  size_mantissa        24  mantissa width incl. hidden bit; stored fraction = size_mantissa-1
//  size_exponent         8  exponent width
//  size_exception_field  2  exception field width
//  size_flush_counter   16  width of saturating denormal-flush counter
//  zero/normal_number/infinity/NaN  0/1/2/3  exception encodings
//  ieee_size     = size_exponent+size_mantissa                (32)
//  size          = size_mantissa+size_exponent+size_exception_field (34)
// PORTS
//  clk_i          in   1          clock, all state on rising edge
//  rst_n_i        in   1          asynchronous active-low reset
//  valid_i        in   1          input pair valid
//  ready_o        out  1          block can accept a pair this cycle
//  sub_i          in   1          1 = A-B, 0 = A+B
//  a_ieee_i       in   ieee_size  operand A, IEEE {s,e,f}
//  b_ieee_i       in   ieee_size  operand B, IEEE {s,e,f}
//  valid_o        out  1          output pair valid
//  ready_i        in   1          adder side accepts pair
//  sub_o          out  1          registered sub flag
//  a_number_o     out  size       operand A, internal format
//  b_number_o     out  size       operand B, internal format
//  flush_clr_i    in   1          synchronous clear of flush counter
//  flush_cnt_o    out  size_flush_counter  denormals flushed (saturating)
// BEHAVIOUR
//  Reset (async, rst_n_i=0): s1/s2 valid=0, all data regs=0, flush_cnt_o=0. valid_o=0, a/b_number_o=0, sub_o=0.
//   In-flight pairs are dropped; no output for them after reset release.
//  Pipeline: S1 registers raw operands + per-operand class; S2 registers the formatted internal words.
//   Outputs are driven from S2 regs only.
//  Handshake: transfer when valid&ready on the same edge. s2_adv = !s2_valid | ready_i.
//   s1_adv = !s1_valid | s2_adv. ready_o = s1_adv (combinational from ready_i).
//  Latency: 2 cycles accept->valid_o when unstalled. Throughput: 1 pair/cycle.
//  valid_o and data are held stable while valid_o=1 and ready_i=0. No bubbles are inserted when ready_i stays 1.
//  Classification per operand, e = exponent field, f = fraction field:
//   e==0,   f==0   -> zero; {zero, s, 0, 0}
//   e==0,   f!=0   -> denormal, flushed; {zero, s, 0, 0}; counts as one flush
//   e==max, f==0   -> infinity; {infinity, s, e, 0}
//   e==max, f!=0   -> NaN; {NaN, s, e, f}
//   otherwise      -> {normal_number, s, e, f}
//  Flush counter:
//   - Increments by 0/1/2 on the S1 accept edge (valid_i&ready_o), once per denormal operand in the pair.
//   - Saturates at all-ones with no wrap.
//   - flush_clr_i wins over the old value: counter <= increment of that cycle.
//  A stalled pair is never counted twice. Rejected input (ready_o=0) is never counted.
// TESTING
//  1 normal: A=0x3F800000, B=0x40000000, sub_i=0, ready_i=1 -> 2 cycles later valid_o=1,
//    a_number_o={01,0,0x7F,0}, b_number_o={01,0,0x80,0}, sub_o=0.
//  2 specials: A=0x7F800000, B=0xFFC00001 -> a exc=10 frac=0; b exc=11, sign=1, frac=0x400001.
//  3 denormals: A=0x00000001, B=0x80400000 -> both exc=00 with exp/frac=0; B sign=1; flush_cnt_o 0->2.
//  4 backpressure: stream 4 pairs; ready_i=0 for 3 cycles mid-stream -> ready_o drops once both stages full;
//    output order kept; no pair lost or duplicated; outputs stable during stall.
//  5 saturation/clear:
//    - Preload to 0xFFFF, send a denormal -> stays 0xFFFF.
//    - flush_clr_i with a 1-denormal accept -> 1.
//  6 reset mid-flight: rst_n_i=0 with both stages valid -> valid_o=0 immediately; flush_cnt_o=0;
//    after release the first new pair emerges 2 cycles after accept.

Source files
------------

// File: rtl/fp_ieee_pair_unpacker.sv
// Operand front end for the FP adder: unpacks an IEEE-754 operand pair into the
// internal {exception, sign, exponent, fraction} format through a 2-stage elastic pipeline.
module fp_ieee_pair_unpacker #(
  parameter int size_mantissa        = 24,
  parameter int size_exponent        = 8,
  parameter int size_exception_field = 2,
  parameter int size_flush_counter   = 16,
  parameter logic [size_exception_field-1:0] zero          = 0,
  parameter logic [size_exception_field-1:0] normal_number = 1,
  parameter logic [size_exception_field-1:0] infinity      = 2,
  parameter logic [size_exception_field-1:0] NaN           = 3,
  parameter int ieee_size = size_exponent + size_mantissa,
  parameter int size      = size_mantissa + size_exponent + size_exception_field
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          sub_i,
  input  logic [ieee_size-1:0]          a_ieee_i,
  input  logic [ieee_size-1:0]          b_ieee_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          sub_o,
  output logic [size-1:0]               a_number_o,
  output logic [size-1:0]               b_number_o,
  input  logic                          flush_clr_i,
  output logic [size_flush_counter-1:0] flush_cnt_o
);

  localparam int frac_w = size_mantissa - 1;

  function automatic logic exp_is_zero(input logic [ieee_size-1:0] x);
    return x[ieee_size-2 -: size_exponent] == '0;
  endfunction

  function automatic logic exp_is_max(input logic [ieee_size-1:0] x);
    return &x[ieee_size-2 -: size_exponent];
  endfunction

  function automatic logic frac_is_zero(input logic [ieee_size-1:0] x);
    return x[frac_w-1:0] == '0;
  endfunction

  function automatic logic [size_exception_field-1:0] classify(input logic [ieee_size-1:0] x);
    logic [size_exception_field-1:0] cls;
    if (exp_is_zero(x))     cls = zero;
    else if (exp_is_max(x)) cls = frac_is_zero(x) ? infinity : NaN;
    else                    cls = normal_number;
    return cls;
  endfunction

  // Zero (including flushed denormals) keeps only the sign; infinity drops its fraction.
  function automatic logic [size-1:0] format(input logic [ieee_size-1:0] x,
                                             input logic [size_exception_field-1:0] cls);
    logic [size-1:0] word;
    if (cls == zero)          word = {zero, x[ieee_size-1], {(ieee_size-1){1'b0}}};
    else if (cls == infinity) word = {infinity, x[ieee_size-1:frac_w], {frac_w{1'b0}}};
    else                      word = {cls, x};
    return word;
  endfunction

  function automatic logic is_denormal(input logic [ieee_size-1:0] x);
    return exp_is_zero(x) && !frac_is_zero(x);
  endfunction

  logic                            s1_valid_reg, s2_valid_reg;
  logic                            s1_sub_reg, s2_sub_reg;
  logic [ieee_size-1:0]            s1_a_reg, s1_b_reg;
  logic [size_exception_field-1:0] s1_a_cls_reg, s1_b_cls_reg;
  logic [size-1:0]                 s2_a_reg, s2_b_reg;
  logic [size_flush_counter-1:0]   flush_cnt_reg, flush_cnt_next;
  logic                            s1_adv, s2_adv, accept;
  logic [1:0]                      flush_inc;
  logic [size_flush_counter:0]     flush_sum;

  assign s2_adv  = !s2_valid_reg || ready_i;
  assign s1_adv  = !s1_valid_reg || s2_adv;
  assign ready_o = s1_adv;
  assign accept  = valid_i && s1_adv;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_reg <= 1'b0;
      s1_sub_reg   <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_a_cls_reg <= '0;
      s1_b_cls_reg <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= valid_i;
      if (valid_i) begin
        s1_sub_reg   <= sub_i;
        s1_a_reg     <= a_ieee_i;
        s1_b_reg     <= b_ieee_i;
        s1_a_cls_reg <= classify(a_ieee_i);
        s1_b_cls_reg <= classify(b_ieee_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_reg <= 1'b0;
      s2_sub_reg   <= 1'b0;
      s2_a_reg     <= '0;
      s2_b_reg     <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sub_reg <= s1_sub_reg;
        s2_a_reg   <= format(s1_a_reg, s1_a_cls_reg);
        s2_b_reg   <= format(s1_b_reg, s1_b_cls_reg);
      end
    end
  end

  // Counting only on the accept edge means a stalled pair is never counted twice.
  always_comb begin
    flush_inc = 2'd0;
    if (accept) flush_inc = 2'(is_denormal(a_ieee_i)) + 2'(is_denormal(b_ieee_i));
    flush_sum = {1'b0, flush_cnt_reg} + {{(size_flush_counter-1){1'b0}}, flush_inc};
    if (flush_clr_i)                      flush_cnt_next = {{(size_flush_counter-2){1'b0}}, flush_inc};
    else if (flush_sum[size_flush_counter]) flush_cnt_next = '1;
    else                                  flush_cnt_next = flush_sum[size_flush_counter-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) flush_cnt_reg <= '0;
    else          flush_cnt_reg <= flush_cnt_next;
  end

  assign valid_o     = s2_valid_reg;
  assign sub_o       = s2_sub_reg;
  assign a_number_o  = s2_a_reg;
  assign b_number_o  = s2_b_reg;
  assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_fp_ieee_pair_unpacker.sv
// Bench for fp_ieee_pair_unpacker: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based transaction model.
module tb_fp_ieee_pair_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, ready_o, sub_i, valid_o, ready_i, sub_o, flush_clr_i;
  logic [31:0] a_ieee_i, b_ieee_i;
  logic [33:0] a_number_o, b_number_o;
  logic [15:0] flush_cnt_o;

  fp_ieee_pair_unpacker dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o), .sub_i(sub_i),
    .a_ieee_i(a_ieee_i), .b_ieee_i(b_ieee_i), .valid_o(valid_o), .ready_i(ready_i),
    .sub_o(sub_o), .a_number_o(a_number_o), .b_number_o(b_number_o),
    .flush_clr_i(flush_clr_i), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: IEEE word -> internal word, from the classification rules
  function automatic logic [33:0] ref_unpack(input logic [31:0] x);
    int unsigned e = x[30:23];
    int unsigned f = x[22:0];
    logic        s = x[31];
    if (e == 0)   return {2'd0, s, 31'd0};
    if (e == 255) return (f == 0) ? {2'd2, s, 8'd255, 23'd0} : {2'd3, x};
    return {2'd1, x};
  endfunction

  function automatic int ref_denorm(input logic [31:0] x);
    return (x[30:23] == 8'd0 && x[22:0] != 23'd0) ? 1 : 0;
  endfunction

  typedef struct { logic [33:0] a; logic [33:0] b; logic sub; } pair_t;
  pair_t q[$];
  int    mcnt = 0;
  logic  held_valid = 1'b0;
  pair_t held;

  // Transaction monitor: runs every falling edge, inputs are stable then.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
      held_valid = 1'b0;
    end else begin
      bit    exp_ready, acc;
      pair_t got, exp;
      int    inc;
      exp_ready = !(q.size() >= 2 && !ready_i);
      check("ready_o", ready_o, exp_ready);
      check("flush_cnt", flush_cnt_o, mcnt);
      if (held_valid) begin
        check("stall_valid", valid_o, 1'b1);
        check("stall_a", a_number_o, held.a);
        check("stall_b", b_number_o, held.b);
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          exp = q.pop_front();
          got = '{a_number_o, b_number_o, sub_o};
          check("out_a", got.a, exp.a);
          check("out_b", got.b, exp.b);
          check("out_sub", got.sub, exp.sub);
        end
      end
      acc = valid_i && exp_ready;
      inc = 0;
      if (acc) begin
        q.push_back('{ref_unpack(a_ieee_i), ref_unpack(b_ieee_i), sub_i});
        inc = ref_denorm(a_ieee_i) + ref_denorm(b_ieee_i);
      end
      if (flush_clr_i) mcnt = inc;
      else mcnt = (mcnt + inc > 65535) ? 65535 : mcnt + inc;
      held_valid = valid_o && !ready_i;
      held = '{a_number_o, b_number_o, sub_o};
    end
  end

  typedef struct {
    logic [31:0] a; logic [31:0] b; logic sub;
    logic [33:0] ea; logic [33:0] eb; logic [15:0] ecnt;
  } vec_t;
  vec_t vecs[3];

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    valid_i = v; a_ieee_i = a; b_ieee_i = b; sub_i = s;
  endtask

  // Present one pair for one cycle, then expect valid_o exactly two cycles after presentation.
  task automatic one_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [33:0] ea, input logic [33:0] eb);
    @(posedge clk); #1 drive(1'b1, a, b, s);
    @(posedge clk); #1 drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk); check({tag, "_lat1_valid"}, valid_o, 1'b0);
    @(negedge clk); check({tag, "_lat2_valid"}, valid_o, 1'b1);
    check({tag, "_a"}, a_number_o, ea);
    check({tag, "_b"}, b_number_o, eb);
    check({tag, "_sub"}, sub_o, s);
  endtask

  function automatic logic [31:0] rand_op();
    logic        s = 1'($urandom);
    logic [22:0] f = 23'($urandom);
    logic [7:0]  e;
    case ($urandom_range(0, 5))
      0: return {s, 31'd0};
      1: return {s, 8'd0, (f == 0) ? 23'd1 : f};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'hFF, (f == 0) ? 23'd5 : f};
      default: begin
        e = 8'($urandom_range(1, 254));
        return {s, e, f};
      end
    endcase
  endfunction

  initial begin
    int k;
    bit saw_stall;
    vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 34'h13F800000, 34'h140000000, 16'd0};
    vecs[1] = '{32'h7F800000, 32'hFFC00001, 1'b1, 34'h27F800000, 34'h3FFC00001, 16'd0};
    vecs[2] = '{32'h00000001, 32'h80400000, 1'b0, 34'h000000000, 34'h080000000, 16'd2};

    rst_n = 1'b0; ready_i = 1'b1; flush_clr_i = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    #12;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_a", a_number_o, 34'd0);
    check("rst_b", b_number_o, 34'd0);
    check("rst_sub", sub_o, 1'b0);
    check("rst_cnt", flush_cnt_o, 16'd0);
    #11 rst_n = 1'b1;

    // Directed vectors
    foreach (vecs[i]) begin
      one_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ea, vecs[i].eb);
      check($sformatf("vec%0d_cnt", i), flush_cnt_o, vecs[i].ecnt);
      $display("[TB] vector %0d a=%h b=%h -> a_num=%h b_num=%h cnt=%0d",
               i, vecs[i].a, vecs[i].b, a_number_o, b_number_o, flush_cnt_o);
    end

    // Backpressure: 4 pairs, ready_i low for 3 cycles mid-stream
    k = 0; saw_stall = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      ready_i = !(c >= 2 && c < 5);
      if (k < 4) drive(1'b1, 32'h3F800000 + k, 32'h40000000 + k, k[0]);
      else       drive(1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      if (!ready_o) saw_stall = 1;
      if (valid_i && ready_o) k++;
    end
    check("bp_ready_dropped", saw_stall, 1'b1);
    check("bp_all_accepted", k, 4);
    check("bp_all_delivered", q.size(), 0);
    $display("[TB] backpressure stream accepted=%0d stalled=%0d", k, saw_stall);

    // Saturation: both operands denormal for enough pairs to overflow 16 bits
    @(posedge clk); #1 drive(1'b1, 32'h00000001, 32'h80000003, 1'b0);
    repeat (32770) @(posedge clk);
    #1 drive(1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("sat_cnt", flush_cnt_o, 16'hFFFF);
    @(posedge clk); #1 drive(1'b1, 32'h00000001, 32'h80000003, 1'b0);
    @(posedge clk); #1 drive(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk); check("sat_hold", flush_cnt_o, 16'hFFFF);
    @(posedge clk); #1 drive(1'b1, 32'h00000001, 32'h3F800000, 1'b0); flush_clr_i = 1'b1;
    @(posedge clk); #1 drive(1'b0, 32'd0, 32'd0, 1'b0); flush_clr_i = 1'b0;
    @(negedge clk); check("clr_cnt", flush_cnt_o, 16'd1);
    $display("[TB] saturation/clear cnt=%0d", flush_cnt_o);
    repeat (3) @(negedge clk);

    // Reset with both stages full
    ready_i = 1'b0;
    @(posedge clk); #1 drive(1'b1, 32'h00000002, 32'h40400000, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_valid", valid_o, 1'b0);
    check("rstf_cnt", flush_cnt_o, 16'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); check("rstf_no_ghost", valid_o, 1'b0);
    one_pair("post_rst", 32'hC0A00000, 32'h00000000, 1'b1, 34'h1C0A00000, 34'h000000000);
    $display("[TB] reset mid-flight, first new pair a_num=%h", a_number_o);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      drive(($urandom_range(0, 9) < 7), rand_op(), rand_op(), 1'($urandom));
      ready_i = ($urandom_range(0, 9) < 7);
      flush_clr_i = ($urandom_range(0, 19) == 0);
      if (c % 50 == 0) $display("[TB] random cycle %0d a=%h b=%h", c, a_ieee_i, b_ieee_i);
    end
    @(posedge clk); #1 drive(1'b0, 32'd0, 32'd0, 1'b0); ready_i = 1'b1; flush_clr_i = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
